rx_cmd_sequencer: RTL and testbench
===================================

RX_CMD_SEQUENCER -- requirements
Module: rx_cmd_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1000, max clocks allowed between bytes of one frame.
REQ-002 SHALL have parameter ROWS, default 16, number of valid board rows.
REQ-003 SHALL have parameter COLS, default 16, number of valid board columns.
REQ-004 SHALL have port clock  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port rxdata  input  8  received byte, stable while rxfinish high.
REQ-007 SHALL have port rxfinish  input  1  receiver done level, high from byte end until next start bit.
REQ-008 SHALL have port cmd_valid  output  1  decoded command available.
REQ-009 SHALL have port cmd_ready  input  1  downstream accepts command when high with cmd_valid.
REQ-010 SHALL have port cmd_op  output  2  0=reveal ('R' 0x52), 1=flag ('F' 0x46), 2=new game ('N' 0x4E).
REQ-011 SHALL have port cmd_row  output  8  target row (0 for new game).
REQ-012 SHALL have port cmd_col  output  8  target column (0 for new game).
REQ-013 SHALL have port err  output  1  one-cycle error pulse.
REQ-014 SHALL have port err_code  output  3  1=BADOP, 2=RANGE, 3=TIMEOUT, 4=OVERRUN, 5=CHECKSUM; held until next err.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-016 Byte event SHALL be rxfinish high while registered rxfinish_d low; one event per received byte.
REQ-017 FSM states SHALL be IDLE, GET_ROW, GET_COL, GET_SUM (macro only), HOLD.
REQ-018 IDLE + event: 'R'/'F' -> GET_ROW; 'N' -> HOLD (or GET_SUM with macro); other byte -> err BADOP, stay IDLE.
REQ-019 GET_ROW + event: latch row -> GET_COL.
REQ-020 GET_COL + event: latch col; row>=ROWS or col>=COLS -> err RANGE, IDLE; else HOLD (or GET_SUM with macro).
REQ-021 HOLD SHALL assert cmd_valid with cmd_op/row/col stable; cmd_valid & cmd_ready -> IDLE next edge.
REQ-022 Latency: cmd_valid SHALL be high from the clock edge that samples the final byte's rxfinish high.
REQ-023 Byte event in HOLD SHALL be dropped with err OVERRUN; held command is unchanged.
REQ-024 Inter-byte counter SHALL clear on each event and count in GET_* states; reaching TIMEOUT-1 -> err TIMEOUT, IDLE.
REQ-025 Byte event and timeout expiry on the same edge: byte event SHALL win, no error.
REQ-026 err SHALL pulse exactly one cycle per error; err_code updated on the same edge.
REQ-027 rxfinish already high when leaving reset SHALL NOT produce a byte event.

Reset
REQ-028 On reset low: state IDLE, cmd_valid 0, cmd_op 0, cmd_row 0, cmd_col 0, err 0, err_code 0, busy 0, counter 0.
REQ-029 rxfinish_d SHALL reset to 1.
REQ-030 Reset mid-frame or in HOLD SHALL discard the partial or held command with no err pulse.

Configuration
REQ-031 Macro RX_CMD_CHECKSUM_EN defined: each frame SHALL end with a byte equal to the XOR of all previous bytes, checked in GET_SUM.
REQ-032 With the macro, a mismatch -> err CHECKSUM, IDLE; a match -> HOLD; the RANGE check still precedes GET_SUM.
REQ-033 Without the macro, GET_SUM and code 5 SHALL NOT exist; frames end at opcode ('N') or col byte.

Verification
REQ-034 Bytes 0x52,0x03,0x07 (no macro), cmd_ready=1 -> one-cycle cmd_valid, op=0, row=3, col=7, no err.
REQ-035 Byte 0x41 in IDLE -> err pulse, err_code=1, busy stays 0.
REQ-036 0x46,0x10,0x02 with ROWS=16 -> err_code=2, no cmd_valid.
REQ-037 0x52 then silence for TIMEOUT clocks -> err_code=3, state IDLE; byte on expiry edge instead -> accepted.
REQ-038 'N' with cmd_ready=0, then 0x52 -> err_code=4; cmd_op=2 held; cmd_ready=1 -> accepted, IDLE.
REQ-039 Macro on: 0x52,0x01,0x02,0x51 -> cmd_valid; last byte 0x50 -> err_code=5; reset low mid-frame -> all outputs 0.

Source files
------------

// File: rtl/rx_cmd_sequencer.sv
// rx_cmd_sequencer: turns received UART bytes into reveal/flag/new-game commands with range, timeout and overrun checks.
// Optional feature: define RX_CMD_CHECKSUM_EN to require a trailing XOR checksum byte per frame.
module rx_cmd_sequencer #(
    parameter int TIMEOUT = 1000,
    parameter int ROWS    = 16,
    parameter int COLS    = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] rxdata,
    input  logic       rxfinish,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [1:0] cmd_op,
    output logic [7:0] cmd_row,
    output logic [7:0] cmd_col,
    output logic       err,
    output logic [2:0] err_code,
    output logic       busy
);
    localparam int              CW          = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   TLAST       = CW'(TIMEOUT - 1);
    localparam logic [8:0]      ROW_LIM     = 9'(ROWS);
    localparam logic [8:0]      COL_LIM     = 9'(COLS);
    localparam logic [7:0]      OP_R        = 8'h52;
    localparam logic [7:0]      OP_F        = 8'h46;
    localparam logic [7:0]      OP_N        = 8'h4E;
    localparam logic [2:0]      ERR_BADOP   = 3'd1;
    localparam logic [2:0]      ERR_RANGE   = 3'd2;
    localparam logic [2:0]      ERR_TIMEOUT = 3'd3;
    localparam logic [2:0]      ERR_OVERRUN = 3'd4;
`ifdef RX_CMD_CHECKSUM_EN
    localparam logic [2:0]      ERR_SUM     = 3'd5;
`endif

    typedef enum logic [2:0] {
        IDLE,
        GET_ROW,
        GET_COL,
`ifdef RX_CMD_CHECKSUM_EN
        GET_SUM,
`endif
        HOLD
    } state_t;

    state_t        state;
    logic          rxfinish_d;
    logic [CW-1:0] cnt;
    logic          ev;
    logic          in_get;
    logic          expire;
    logic          bad_range;
`ifdef RX_CMD_CHECKSUM_EN
    logic [7:0]    sum;
`endif

    assign ev        = rxfinish & ~rxfinish_d;
`ifdef RX_CMD_CHECKSUM_EN
    assign in_get    = (state == GET_ROW) || (state == GET_COL) || (state == GET_SUM);
`else
    assign in_get    = (state == GET_ROW) || (state == GET_COL);
`endif
    assign expire    = in_get && !ev && (cnt == TLAST);
    assign bad_range = ({1'b0, cmd_row} >= ROW_LIM) || ({1'b0, rxdata} >= COL_LIM);

    // Frame sequencer: byte edge detect, inter-byte timer, decode and command hold/handshake
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            rxfinish_d <= 1'b1;
            cnt        <= '0;
            cmd_valid  <= 1'b0;
            cmd_op     <= 2'd0;
            cmd_row    <= 8'd0;
            cmd_col    <= 8'd0;
            err        <= 1'b0;
            err_code   <= 3'd0;
            busy       <= 1'b0;
`ifdef RX_CMD_CHECKSUM_EN
            sum        <= 8'd0;
`endif
        end else begin
            rxfinish_d <= rxfinish;
            err        <= 1'b0;
            cnt        <= (in_get && !ev && !expire) ? cnt + 1'b1 : '0;
            if (expire) begin
                err      <= 1'b1;
                err_code <= ERR_TIMEOUT;
                state    <= IDLE;
                busy     <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (ev) begin
                        if (rxdata == OP_R || rxdata == OP_F) begin
                            cmd_op <= (rxdata == OP_R) ? 2'd0 : 2'd1;
                            state  <= GET_ROW;
                            busy   <= 1'b1;
                        end else if (rxdata == OP_N) begin
                            cmd_op    <= 2'd2;
                            cmd_row   <= 8'd0;
                            cmd_col   <= 8'd0;
                            busy      <= 1'b1;
`ifdef RX_CMD_CHECKSUM_EN
                            state     <= GET_SUM;
`else
                            state     <= HOLD;
                            cmd_valid <= 1'b1;
`endif
                        end else begin
                            err      <= 1'b1;
                            err_code <= ERR_BADOP;
                        end
`ifdef RX_CMD_CHECKSUM_EN
                        sum <= rxdata;
`endif
                    end
                    GET_ROW: if (ev) begin
                        cmd_row <= rxdata;
                        state   <= GET_COL;
`ifdef RX_CMD_CHECKSUM_EN
                        sum     <= sum ^ rxdata;
`endif
                    end
                    GET_COL: if (ev) begin
                        cmd_col <= rxdata;
                        if (bad_range) begin
                            err      <= 1'b1;
                            err_code <= ERR_RANGE;
                            state    <= IDLE;
                            busy     <= 1'b0;
                        end else begin
`ifdef RX_CMD_CHECKSUM_EN
                            state     <= GET_SUM;
                            sum       <= sum ^ rxdata;
`else
                            state     <= HOLD;
                            cmd_valid <= 1'b1;
`endif
                        end
                    end
`ifdef RX_CMD_CHECKSUM_EN
                    GET_SUM: if (ev) begin
                        if (rxdata == sum) begin
                            state     <= HOLD;
                            cmd_valid <= 1'b1;
                        end else begin
                            err      <= 1'b1;
                            err_code <= ERR_SUM;
                            state    <= IDLE;
                            busy     <= 1'b0;
                        end
                    end
`endif
                    HOLD: begin
                        if (ev) begin
                            err      <= 1'b1;
                            err_code <= ERR_OVERRUN;
                        end
                        if (cmd_ready) begin
                            state     <= IDLE;
                            cmd_valid <= 1'b0;
                            busy      <= 1'b0;
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        cmd_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_rx_cmd_sequencer.sv
// tb_rx_cmd_sequencer: scoreboard bench for rx_cmd_sequencer; expected commands and error codes are queued as bytes are driven.
module tb_rx_cmd_sequencer;
    localparam int TO   = 20;
    localparam int ROWS = 16;
    localparam int COLS = 16;

    typedef struct packed {
        logic [1:0] op;
        logic [7:0] row;
        logic [7:0] col;
    } cmd_t;

    logic       clock;
    logic       reset;
    logic [7:0] rxdata;
    logic       rxfinish;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_row;
    logic [7:0] cmd_col;
    logic       err;
    logic [2:0] err_code;
    logic       busy;

    cmd_t       cmd_q[$];
    logic [2:0] err_q[$];
    cmd_t       mon_c;
    logic [2:0] mon_e;
    logic [7:0] acc;
    int         n_chk  = 0;
    int         n_fail = 0;

    rx_cmd_sequencer #(.TIMEOUT(TO), .ROWS(ROWS), .COLS(COLS)) dut (
        .clock     (clock),
        .reset     (reset),
        .rxdata    (rxdata),
        .rxfinish  (rxfinish),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_row   (cmd_row),
        .cmd_col   (cmd_col),
        .err       (err),
        .err_code  (err_code),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clock);
        rxfinish = 1'b0;
        @(negedge clock);
        rxdata   = b;
        rxfinish = 1'b1;
        acc      = acc ^ b;
        @(posedge clock);
        #1;
    endtask

    task automatic end_frame();
`ifdef RX_CMD_CHECKSUM_EN
        send_byte(acc);
`endif
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("reach_idle", 32'(busy), 0);
    endtask

    // Output monitor: inputs change on falling edges, so just after one the handshake for the next rising edge is settled
    always begin
        @(negedge clock);
        #1;
        if (reset && cmd_valid && cmd_ready) begin
            chk("cmd_expected", 32'(cmd_q.size() != 0), 1);
            if (cmd_q.size() != 0) begin
                mon_c = cmd_q.pop_front();
                chk("cmd_op", 32'(cmd_op), 32'(mon_c.op));
                chk("cmd_row", 32'(cmd_row), 32'(mon_c.row));
                chk("cmd_col", 32'(cmd_col), 32'(mon_c.col));
            end
        end
        if (err) begin
            chk("err_expected", 32'(err_q.size() != 0), 1);
            if (err_q.size() != 0) begin
                mon_e = err_q.pop_front();
                chk("err_code", 32'(err_code), 32'(mon_e));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        rxfinish  = 1'b1;
        rxdata    = 8'h00;
        cmd_ready = 1'b1;
        acc       = 8'h00;
        repeat (3) @(negedge clock);
        #1;
        chk("rst_cmd_valid", 32'(cmd_valid), 0);
        chk("rst_cmd_op", 32'(cmd_op), 0);
        chk("rst_cmd_row", 32'(cmd_row), 0);
        chk("rst_cmd_col", 32'(cmd_col), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_err_code", 32'(err_code), 0);
        chk("rst_busy", 32'(busy), 0);
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("no_event_after_reset_busy", 32'(busy), 0);
        chk("no_event_after_reset_err_code", 32'(err_code), 0);

        // Reveal 3,7 with ready high: valid on the final byte's edge
        acc = 8'h00;
        cmd_q.push_back(cmd_t'{2'd0, 8'd3, 8'd7});
        send_byte(8'h52);
        send_byte(8'h03);
        send_byte(8'h07);
        end_frame();
        chk("latency_valid", 32'(cmd_valid), 1);
        chk("latency_op", 32'(cmd_op), 0);
        wait_idle();

        // Bad opcode
        err_q.push_back(3'd1);
        acc = 8'h00;
        send_byte(8'h41);
        chk("badop_err", 32'(err), 1);
        chk("badop_busy", 32'(busy), 0);
        repeat (2) @(posedge clock);
        #1;
        chk("badop_busy_later", 32'(busy), 0);

        // Range errors on row and column, and the in-range corner
        acc = 8'h00;
        err_q.push_back(3'd2);
        send_byte(8'h46);
        send_byte(8'h10);
        send_byte(8'h02);
        chk("range_row_valid", 32'(cmd_valid), 0);
        wait_idle();
        acc = 8'h00;
        err_q.push_back(3'd2);
        send_byte(8'h52);
        send_byte(8'h02);
        send_byte(8'h10);
        chk("range_col_valid", 32'(cmd_valid), 0);
        wait_idle();
        acc = 8'h00;
        cmd_q.push_back(cmd_t'{2'd1, 8'd15, 8'd15});
        send_byte(8'h46);
        send_byte(8'h0F);
        send_byte(8'h0F);
        end_frame();
        wait_idle();

        // Timeout after TO silent clocks
        acc = 8'h00;
        err_q.push_back(3'd3);
        send_byte(8'h52);
        repeat (TO - 1) @(posedge clock);
        #1;
        chk("timeout_not_yet_busy", 32'(busy), 1);
        chk("timeout_not_yet_err", 32'(err), 0);
        @(posedge clock);
        #1;
        chk("timeout_err", 32'(err), 1);
        chk("timeout_code", 32'(err_code), 3);
        chk("timeout_idle", 32'(busy), 0);

        // Byte landing on the expiry edge wins
        acc = 8'h00;
        cmd_q.push_back(cmd_t'{2'd0, 8'd3, 8'd5});
        send_byte(8'h52);
        @(negedge clock);
        rxfinish = 1'b0;
        repeat (TO - 1) @(negedge clock);
        rxdata   = 8'h03;
        rxfinish = 1'b1;
        acc      = acc ^ 8'h03;
        @(posedge clock);
        #1;
        chk("expiry_edge_err", 32'(err), 0);
        chk("expiry_edge_busy", 32'(busy), 1);
        send_byte(8'h05);
        end_frame();
        wait_idle();

        // Overrun while a new-game command is held
        cmd_ready = 1'b0;
        acc = 8'h00;
        cmd_q.push_back(cmd_t'{2'd2, 8'd0, 8'd0});
        send_byte(8'h4E);
        end_frame();
        chk("hold_valid", 32'(cmd_valid), 1);
        repeat (3) @(posedge clock);
        err_q.push_back(3'd4);
        send_byte(8'h52);
        chk("overrun_err", 32'(err), 1);
        chk("overrun_op_held", 32'(cmd_op), 2);
        chk("overrun_valid_held", 32'(cmd_valid), 1);
        @(negedge clock);
        cmd_ready = 1'b1;
        wait_idle();
        chk("overrun_released_valid", 32'(cmd_valid), 0);

        // Reset mid-frame discards silently
        acc = 8'h00;
        send_byte(8'h52);
        send_byte(8'h01);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_row", 32'(cmd_row), 0);
        chk("midrst_err_code", 32'(err_code), 0);
        chk("midrst_err", 32'(err), 0);
        @(negedge clock);
        reset = 1'b1;

        // Reset while holding discards the command
        cmd_ready = 1'b0;
        acc = 8'h00;
        send_byte(8'h46);
        send_byte(8'h02);
        send_byte(8'h03);
        end_frame();
        chk("hold_before_rst", 32'(cmd_valid), 1);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("hold_rst_valid", 32'(cmd_valid), 0);
        chk("hold_rst_col", 32'(cmd_col), 0);
        @(negedge clock);
        reset     = 1'b1;
        cmd_ready = 1'b1;
        repeat (3) @(posedge clock);

`ifdef RX_CMD_CHECKSUM_EN
        acc = 8'h00;
        cmd_q.push_back(cmd_t'{2'd0, 8'd1, 8'd2});
        send_byte(8'h52);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h51);
        chk("sum_ok_valid", 32'(cmd_valid), 1);
        wait_idle();
        acc = 8'h00;
        err_q.push_back(3'd5);
        send_byte(8'h52);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h50);
        chk("sum_bad_valid", 32'(cmd_valid), 0);
        wait_idle();
`endif

        // Random legal frames with random backpressure
        for (int i = 0; i < 8; i++) begin
            int         k;
            logic [7:0] r;
            logic [7:0] c;
            k = int'($urandom_range(0, 2));
            r = 8'($urandom_range(0, ROWS - 1));
            c = 8'($urandom_range(0, COLS - 1));
            cmd_ready = 1'($urandom_range(0, 1));
            acc = 8'h00;
            if (k == 2) begin
                cmd_q.push_back(cmd_t'{2'd2, 8'd0, 8'd0});
                send_byte(8'h4E);
            end else begin
                cmd_q.push_back(cmd_t'{2'(k), r, c});
                send_byte(k == 0 ? 8'h52 : 8'h46);
                send_byte(r);
                send_byte(c);
            end
            end_frame();
            repeat ($urandom_range(0, 3)) @(negedge clock);
            @(negedge clock);
            cmd_ready = 1'b1;
            wait_idle();
        end

        repeat (5) @(negedge clock);
        chk("cmd_q_drained", 32'(cmd_q.size()), 0);
        chk("err_q_drained", 32'(err_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
